// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier/divider units for the control FSM: start pulse,
// bounded wait for the finish flag, one-cycle HI/LO write, then done or exception.
module muldiv_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic             op_div,
    input  logic             abort,
    input  logic             mult_fim,
    input  logic             div_fim,
    input  logic             DividedByZero,
    output logic             mult_start,
    output logic             div_start,
    output logic             HISelector,
    output logic             LOSelector,
    output logic             RegHIWrite,
    output logic             RegLOWrite,
    output logic             busy,
    output logic             done,
    output logic             exc,
    output logic [1:0]       exc_cause,
    output logic [CNT_W-1:0] latency
);

    typedef enum logic [2:0] {IDLE, START, WAIT, WRITE, DONE, EXC} stateType;

    localparam logic [CNT_W-1:0] lastCount = CNT_W'(TIMEOUT - 1);

    stateType         state;
    stateType         nextState;
    logic             opDiv;
    logic [CNT_W-1:0] counter;
    logic [1:0]       excCause;
    logic [CNT_W-1:0] lastLatency;
    logic             unitFim;

    // Only the finish flag of the unit that was actually started matters.
    assign unitFim = opDiv ? div_fim : mult_fim;

    always_comb begin
        nextState  = state;
        mult_start = 1'b0;
        div_start  = 1'b0;
        HISelector = 1'b0;
        LOSelector = 1'b0;
        RegHIWrite = 1'b0;
        RegLOWrite = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        exc        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req) nextState = START;
            end
            START: begin
                mult_start = ~opDiv;
                div_start  = opDiv;
                HISelector = opDiv;
                LOSelector = opDiv;
                nextState  = WAIT;
            end
            WAIT: begin
                HISelector = opDiv;
                LOSelector = opDiv;
                // Divide-by-zero beats a simultaneous finish so no bogus result is written.
                if (abort)                         nextState = IDLE;
                else if (opDiv && DividedByZero)   nextState = EXC;
                else if (unitFim)                  nextState = WRITE;
                else if (counter == lastCount)     nextState = EXC;
            end
            WRITE: begin
                HISelector = opDiv;
                LOSelector = opDiv;
                RegHIWrite = 1'b1;
                RegLOWrite = 1'b1;
                nextState  = DONE;
            end
            DONE: begin
                HISelector = opDiv;
                LOSelector = opDiv;
                done       = 1'b1;
                nextState  = IDLE;
            end
            EXC: begin
                exc       = 1'b1;
                nextState = IDLE;
            end
            default: begin
                busy      = 1'b0;
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            opDiv       <= 1'b0;
            counter     <= '0;
            excCause    <= 2'b00;
            lastLatency <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (req) begin
                        opDiv    <= op_div;
                        excCause <= 2'b00;
                    end
                end
                START: counter <= '0;
                WAIT: begin
                    // Saturating so a stuck unit can never wrap past the timeout check.
                    if (counter != lastCount) counter <= counter + CNT_W'(1);
                    if (nextState == WRITE) lastLatency <= counter + CNT_W'(1);
                    if (nextState == EXC)
                        excCause <= (opDiv && DividedByZero) ? 2'b01 : 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign exc_cause = excCause;
    assign latency   = lastLatency;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: each scenario task drives vectors and checks
// outputs against hand-derived cycle-by-cycle expectations.
module tb_muldiv_sequencer;

    localparam int CNT_W = 7;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             req = 1'b0;
    logic             op_div = 1'b0;
    logic             abort = 1'b0;
    logic             mult_fim = 1'b0;
    logic             div_fim = 1'b0;
    logic             DividedByZero = 1'b0;
    logic             mult_start;
    logic             div_start;
    logic             HISelector;
    logic             LOSelector;
    logic             RegHIWrite;
    logic             RegLOWrite;
    logic             busy;
    logic             done;
    logic             exc;
    logic [1:0]       exc_cause;
    logic [CNT_W-1:0] latency;

    int testCount = 0;
    int failCount = 0;

    int multStartSeen = 0;
    int divStartSeen  = 0;
    int writeSeen     = 0;
    int doneSeen      = 0;
    int excSeen       = 0;

    logic [10+CNT_W:0] allOuts;
    assign allOuts = {mult_start, div_start, HISelector, LOSelector, RegHIWrite,
                      RegLOWrite, busy, done, exc, exc_cause, latency};

    muldiv_sequencer #(.TIMEOUT(64), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .req(req), .op_div(op_div), .abort(abort),
        .mult_fim(mult_fim), .div_fim(div_fim), .DividedByZero(DividedByZero),
        .mult_start(mult_start), .div_start(div_start),
        .HISelector(HISelector), .LOSelector(LOSelector),
        .RegHIWrite(RegHIWrite), .RegLOWrite(RegLOWrite),
        .busy(busy), .done(done), .exc(exc), .exc_cause(exc_cause), .latency(latency)
    );

    always #5 clock = ~clock;

    // Pulse tallies sampled mid-cycle; scenarios compare deltas across their span.
    always @(negedge clock) begin
        if (mult_start === 1'b1) multStartSeen++;
        if (div_start === 1'b1)  divStartSeen++;
        if (RegHIWrite === 1'b1 || RegLOWrite === 1'b1) writeSeen++;
        if (done === 1'b1)       doneSeen++;
        if (exc === 1'b1)        excSeen++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        int ms0;
        ms0 = multStartSeen;
        req = 1'b1;
        step();
        testCount++;
        if (allOuts !== '0) begin
            $display("[TB] FAIL reset_cycle1: outputs=%0h expected 0", allOuts);
            failCount++;
        end
        step();
        testCount++;
        if (allOuts !== '0) begin
            $display("[TB] FAIL reset_cycle2: outputs=%0h expected 0", allOuts);
            failCount++;
        end
        reset = 1'b1;
        req   = 1'b0;
        step();
        testCount++;
        if (allOuts !== '0 || busy !== 1'b0) begin
            $display("[TB] FAIL reset_release: outputs=%0h expected 0", allOuts);
            failCount++;
        end
        testCount++;
        if (multStartSeen - ms0 != 0) begin
            $display("[TB] FAIL reset_no_start: starts=%0d expected 0", multStartSeen - ms0);
            failCount++;
        end
    endtask

    task automatic test_mult();
        int ms0, ds0, w0, d0;
        ms0 = multStartSeen; ds0 = divStartSeen; w0 = writeSeen; d0 = doneSeen;
        op_div = 1'b0;
        req    = 1'b1;
        step();
        req = 1'b0;
        testCount++;
        if ({mult_start, div_start, busy} !== 3'b101) begin
            $display("[TB] FAIL mult_start_pulse: {ms,ds,busy}=%b expected 101",
                     {mult_start, div_start, busy});
            failCount++;
        end
        step();
        for (int c = 1; c < 33; c++) step();
        mult_fim = 1'b1;
        step();
        mult_fim = 1'b0;
        testCount++;
        if ({RegHIWrite, RegLOWrite, HISelector, LOSelector} !== 4'b1100) begin
            $display("[TB] FAIL mult_write: {hiw,low,hisel,losel}=%b expected 1100",
                     {RegHIWrite, RegLOWrite, HISelector, LOSelector});
            failCount++;
        end
        testCount++;
        if (latency !== 7'd33) begin
            $display("[TB] FAIL mult_latency: latency=%0d expected 33", latency);
            failCount++;
        end
        step();
        testCount++;
        if ({done, busy, RegHIWrite} !== 3'b110) begin
            $display("[TB] FAIL mult_done: {done,busy,hiw}=%b expected 110",
                     {done, busy, RegHIWrite});
            failCount++;
        end
        step();
        testCount++;
        if ({busy, done} !== 2'b00) begin
            $display("[TB] FAIL mult_idle: {busy,done}=%b expected 00", {busy, done});
            failCount++;
        end
        testCount++;
        if (multStartSeen - ms0 != 1 || divStartSeen - ds0 != 0 ||
            writeSeen - w0 != 1 || doneSeen - d0 != 1) begin
            $display("[TB] FAIL mult_pulses: ms=%0d ds=%0d wr=%0d done=%0d expected 1 0 1 1",
                     multStartSeen - ms0, divStartSeen - ds0, writeSeen - w0, doneSeen - d0);
            failCount++;
        end
    endtask

    task automatic test_div();
        int ms0, ds0;
        ms0 = multStartSeen; ds0 = divStartSeen;
        op_div = 1'b1;
        req    = 1'b1;
        step();
        req    = 1'b0;
        op_div = 1'b0;
        testCount++;
        if ({mult_start, div_start, HISelector} !== 3'b011) begin
            $display("[TB] FAIL div_start_pulse: {ms,ds,hisel}=%b expected 011",
                     {mult_start, div_start, HISelector});
            failCount++;
        end
        step();
        testCount++;
        if (latency !== 7'd33) begin
            $display("[TB] FAIL div_latency_hold: latency=%0d expected 33", latency);
            failCount++;
        end
        step();
        step();
        div_fim = 1'b1;
        step();
        div_fim = 1'b0;
        abort   = 1'b1;
        testCount++;
        if ({RegHIWrite, RegLOWrite, HISelector, LOSelector} !== 4'b1111 || latency !== 7'd3) begin
            $display("[TB] FAIL div_write: {hiw,low,hisel,losel}=%b latency=%0d expected 1111 3",
                     {RegHIWrite, RegLOWrite, HISelector, LOSelector}, latency);
            failCount++;
        end
        step();
        abort = 1'b0;
        testCount++;
        if ({done, HISelector} !== 2'b11) begin
            $display("[TB] FAIL div_done: {done,hisel}=%b expected 11", {done, HISelector});
            failCount++;
        end
        step();
        testCount++;
        if (divStartSeen - ds0 != 1 || multStartSeen - ms0 != 0) begin
            $display("[TB] FAIL div_pulses: ds=%0d ms=%0d expected 1 0",
                     divStartSeen - ds0, multStartSeen - ms0);
            failCount++;
        end
    endtask

    task automatic test_div_by_zero();
        int w0, d0, e0;
        w0 = writeSeen; d0 = doneSeen; e0 = excSeen;
        op_div = 1'b1;
        req    = 1'b1;
        step();
        req = 1'b0;
        step();
        step();
        DividedByZero = 1'b1;
        div_fim       = 1'b1;
        step();
        DividedByZero = 1'b0;
        div_fim       = 1'b0;
        testCount++;
        if ({exc, exc_cause, RegHIWrite, done, busy, HISelector} !== 7'b1010010) begin
            $display("[TB] FAIL dbz_exc: {exc,cause,hiw,done,busy,hisel}=%b expected 1010010",
                     {exc, exc_cause, RegHIWrite, done, busy, HISelector});
            failCount++;
        end
        step();
        testCount++;
        if ({exc, busy} !== 2'b00 || exc_cause !== 2'b01 || latency !== 7'd3) begin
            $display("[TB] FAIL dbz_idle: exc=%b busy=%b cause=%b latency=%0d expected 0 0 01 3",
                     exc, busy, exc_cause, latency);
            failCount++;
        end
        testCount++;
        if (writeSeen - w0 != 0 || doneSeen - d0 != 0 || excSeen - e0 != 1) begin
            $display("[TB] FAIL dbz_pulses: wr=%0d done=%0d exc=%0d expected 0 0 1",
                     writeSeen - w0, doneSeen - d0, excSeen - e0);
            failCount++;
        end
    endtask

    task automatic test_timeout();
        int w0, d0, e0, early;
        w0 = writeSeen; d0 = doneSeen; e0 = excSeen; early = 0;
        op_div = 1'b0;
        req    = 1'b1;
        step();
        req = 1'b0;
        testCount++;
        if (exc_cause !== 2'b00) begin
            $display("[TB] FAIL timeout_cause_clear: cause=%b expected 00", exc_cause);
            failCount++;
        end
        step();
        for (int c = 1; c <= 64; c++) begin
            div_fim       = (c == 10);
            DividedByZero = (c >= 10 && c <= 12);
            if (exc !== 1'b0 || busy !== 1'b1) early++;
            step();
        end
        div_fim       = 1'b0;
        DividedByZero = 1'b0;
        testCount++;
        if (early != 0) begin
            $display("[TB] FAIL timeout_wait: bad wait cycles=%0d expected 0", early);
            failCount++;
        end
        testCount++;
        if ({exc, exc_cause} !== 3'b110) begin
            $display("[TB] FAIL timeout_exc: {exc,cause}=%b expected 110", {exc, exc_cause});
            failCount++;
        end
        step();
        testCount++;
        if (writeSeen - w0 != 0 || doneSeen - d0 != 0 || excSeen - e0 != 1 || busy !== 1'b0) begin
            $display("[TB] FAIL timeout_pulses: wr=%0d done=%0d exc=%0d busy=%b expected 0 0 1 0",
                     writeSeen - w0, doneSeen - d0, excSeen - e0, busy);
            failCount++;
        end
    endtask

    task automatic test_abort();
        int ms0, ds0, w0, d0;
        ms0 = multStartSeen; ds0 = divStartSeen; w0 = writeSeen; d0 = doneSeen;
        op_div = 1'b0;
        req    = 1'b1;
        step();
        req   = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        testCount++;
        if (busy !== 1'b1) begin
            $display("[TB] FAIL abort_in_start: busy=%b expected 1", busy);
            failCount++;
        end
        step();
        req    = 1'b1;
        op_div = 1'b1;
        step();
        req    = 1'b0;
        op_div = 1'b0;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        testCount++;
        if ({busy, done, RegHIWrite} !== 3'b000) begin
            $display("[TB] FAIL abort_idle: {busy,done,hiw}=%b expected 000",
                     {busy, done, RegHIWrite});
            failCount++;
        end
        step();
        testCount++;
        if (busy !== 1'b0 || latency !== 7'd3) begin
            $display("[TB] FAIL abort_no_queue: busy=%b latency=%0d expected 0 3", busy, latency);
            failCount++;
        end
        testCount++;
        if (multStartSeen - ms0 != 1 || divStartSeen - ds0 != 0 ||
            writeSeen - w0 != 0 || doneSeen - d0 != 0) begin
            $display("[TB] FAIL abort_pulses: ms=%0d ds=%0d wr=%0d done=%0d expected 1 0 0 0",
                     multStartSeen - ms0, divStartSeen - ds0, writeSeen - w0, doneSeen - d0);
            failCount++;
        end
    endtask

    task automatic test_reset_mid_wait();
        op_div = 1'b0;
        req    = 1'b1;
        step();
        req = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        testCount++;
        if (allOuts !== '0) begin
            $display("[TB] FAIL reset_mid_wait: outputs=%0h expected 0", allOuts);
            failCount++;
        end
        reset = 1'b1;
        step();
        testCount++;
        if (busy !== 1'b0 || mult_start !== 1'b0) begin
            $display("[TB] FAIL reset_mid_wait_idle: busy=%b ms=%b expected 0 0", busy, mult_start);
            failCount++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_timeout();
        test_abort();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
